input_conditioner: RTL and testbench

Conditions the asynchronous board inputs before they reach the memory-mapped peripheral block that the core reads through its load path. The block synchronizes switches, buttons and input pins into the core clock domain and debounces the buttons. It also records button presses as sticky pending flags, so firmware polling through loads cannot miss a short press. Its outputs replace the raw `sw`/`btn`/`ipin` nets at the peripheral block's inputs. The peripheral block drives the clear strobe on a store to its button-status address.

---
 rtl/input_conditioner.sv | 102 ++++++++++
 tb/tb_input_conditioner.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes raw switches, buttons and input pins into the
// core clock domain, debounces the buttons, and keeps sticky press flags that
// the peripheral store path clears with a write-1-to-clear mask.
module input_conditioner #(
  parameter int N_SW            = 16,
  parameter int N_BTN           = 5,
  parameter int N_IPIN          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SW-1:0]   sw_in,
  input  logic [N_BTN-1:0]  btn_in,
  input  logic [N_IPIN-1:0] ipin_in,
  input  logic              clr_we,
  input  logic [N_BTN-1:0]  clr_mask,
  output logic [N_SW-1:0]   sw_out,
  output logic [N_IPIN-1:0] ipin_out,
  output logic [N_BTN-1:0]  btn_out,
  output logic [N_BTN-1:0]  btn_pulse,
  output logic [N_BTN-1:0]  btn_pend
);

  // Last count value before a differing level is accepted.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_SW-1:0]   sw_s1, sw_s2;
  logic [N_BTN-1:0]  btn_s1, btn_s2;
  logic [N_IPIN-1:0] ipin_s1, ipin_s2;

  logic [CNT_W-1:0]  cnt [N_BTN];
  logic [N_BTN-1:0]  accept;
  logic [N_BTN-1:0]  rise;
  logic [N_BTN-1:0]  clr_bits;

  // Two-flop synchronizers with nothing between the stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1   <= '0;
      sw_s2   <= '0;
      btn_s1  <= '0;
      btn_s2  <= '0;
      ipin_s1 <= '0;
      ipin_s2 <= '0;
    end else begin
      sw_s1   <= sw_in;
      sw_s2   <= sw_s1;
      btn_s1  <= btn_in;
      btn_s2  <= btn_s1;
      ipin_s1 <= ipin_in;
      ipin_s2 <= ipin_s1;
    end
  end

  assign sw_out   = sw_s2;
  assign ipin_out = ipin_s2;

  // A button's new level is accepted once it has differed for the full count.
  always_comb begin
    accept = '0;
    for (int i = 0; i < N_BTN; i++) begin
      accept[i] = (btn_s2[i] != btn_out[i]) && (cnt[i] == CNT_MAX);
    end
  end

  assign rise     = accept & btn_s2;
  assign clr_bits = clr_we ? clr_mask : '0;

  // Per-button debouncer: any return to the stable level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_out <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (btn_s2[i] == btn_out[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          btn_out[i] <= btn_s2[i];
          cnt[i]     <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Rising-edge pulse and sticky pending flags; a set beats a same-edge clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_pulse <= '0;
      btn_pend  <= '0;
    end else begin
      btn_pulse <= rise;
      btn_pend  <= (btn_pend & ~clr_bits) | rise;
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed scenarios, a switch/pin vector table and a
// randomized phase, all compared against a window-based reference model.
module tb_input_conditioner;

  localparam int N_SW  = 16;
  localparam int N_BTN = 5;
  localparam int N_IPIN = 4;
  localparam int DEB   = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N_SW-1:0]   sw_in = '0;
  logic [N_BTN-1:0]  btn_in = '0;
  logic [N_IPIN-1:0] ipin_in = '0;
  logic              clr_we = 1'b0;
  logic [N_BTN-1:0]  clr_mask = '0;
  logic [N_SW-1:0]   sw_out;
  logic [N_IPIN-1:0] ipin_out;
  logic [N_BTN-1:0]  btn_out;
  logic [N_BTN-1:0]  btn_pulse;
  logic [N_BTN-1:0]  btn_pend;

  int checks = 0;
  int errors = 0;

  input_conditioner #(
    .N_SW(N_SW), .N_BTN(N_BTN), .N_IPIN(N_IPIN), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_in(sw_in), .btn_in(btn_in), .ipin_in(ipin_in),
    .clr_we(clr_we), .clr_mask(clr_mask), .sw_out(sw_out), .ipin_out(ipin_out),
    .btn_out(btn_out), .btn_pulse(btn_pulse), .btn_pend(btn_pend)
  );

  // Free-running core clock.
  always #5 clk = ~clk;

  // Reference model: raw samples delayed two edges; a button takes a new level
  // when the last DEB synchronized samples all disagree with its current level.
  typedef struct packed {
    logic [N_SW-1:0]   sw;
    logic [N_BTN-1:0]  btn;
    logic [N_IPIN-1:0] ipin;
  } raw_t;

  raw_t             cap_q[$];
  logic [N_BTN-1:0] hist[$];
  logic [N_BTN-1:0] m_btn, m_pulse, m_pend;

  typedef struct {
    logic [N_SW-1:0]   sw;
    logic [N_IPIN-1:0] ipin;
    logic [N_SW-1:0]   exp_sw;
    logic [N_IPIN-1:0] exp_ipin;
  } sync_vec_t;

  task automatic model_reset();
    raw_t z;
    z = '0;
    cap_q.delete();
    hist.delete();
    cap_q.push_back(z);
    cap_q.push_back(z);
    for (int j = 0; j < DEB; j++) hist.push_back('0);
    m_btn = '0;
    m_pulse = '0;
    m_pend = '0;
  endtask

  task automatic model_edge();
    logic [N_BTN-1:0] flip;
    raw_t r;
    bit all_diff;
    flip = '0;
    for (int i = 0; i < N_BTN; i++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DEB; j++)
        if (hist[hist.size() - 1 - j][i] == m_btn[i]) all_diff = 1'b0;
      flip[i] = all_diff;
    end
    m_pulse = flip & ~m_btn;
    m_btn   = m_btn ^ flip;
    m_pend  = (m_pend & ~(clr_we ? clr_mask : '0)) | m_pulse;
    r.sw = sw_in;
    r.btn = btn_in;
    r.ipin = ipin_in;
    cap_q.push_back(r);
    void'(cap_q.pop_front());
    hist.push_back(cap_q[0].btn);
    if (hist.size() > DEB) void'(hist.pop_front());
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareModel();
    checkOutput("model_sw_out", 32'(sw_out), 32'(cap_q[0].sw));
    checkOutput("model_ipin_out", 32'(ipin_out), 32'(cap_q[0].ipin));
    checkOutput("model_btn_out", 32'(btn_out), 32'(m_btn));
    checkOutput("model_btn_pulse", 32'(btn_pulse), 32'(m_pulse));
    checkOutput("model_btn_pend", 32'(btn_pend), 32'(m_pend));
  endtask

  task automatic applyStimulus(input logic [N_SW-1:0] sw, input logic [N_BTN-1:0] btn,
                               input logic [N_IPIN-1:0] ipin, input logic we,
                               input logic [N_BTN-1:0] mask);
    sw_in = sw;
    btn_in = btn;
    ipin_in = ipin;
    clr_we = we;
    clr_mask = mask;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    #1;
    compareModel();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Main sequence: directed corner cases first, then randomized traffic.
  initial begin
    sync_vec_t vecs[4];
    logic [N_BTN-1:0] bounce[8];
    logic [N_SW-1:0] prev_sw;
    logic [N_IPIN-1:0] prev_ipin;
    int pulses;

    vecs[0] = '{16'hA5C3, 4'h9, 16'hA5C3, 4'h9};
    vecs[1] = '{16'h0000, 4'h0, 16'h0000, 4'h0};
    vecs[2] = '{16'hFFFF, 4'hF, 16'hFFFF, 4'hF};
    vecs[3] = '{16'h1234, 4'h6, 16'h1234, 4'h6};
    bounce = '{5'd1, 5'd1, 5'd1, 5'd0, 5'd1, 5'd1, 5'd1, 5'd0};

    model_reset();
    ticks(2);
    checkOutput("reset_sw_out", 32'(sw_out), 0);
    checkOutput("reset_btn_out", 32'(btn_out), 0);
    checkOutput("reset_btn_pend", 32'(btn_pend), 0);
    rst_n = 1'b1;
    tick();

    // Switch/pin synchronizer table: new value visible after the second edge.
    prev_sw = '0;
    prev_ipin = '0;
    for (int v = 0; v < 4; v++) begin
      applyStimulus(vecs[v].sw, '0, vecs[v].ipin, 1'b0, '0);
      tick();
      checkOutput("sync_sw_early", 32'(sw_out), 32'(prev_sw));
      checkOutput("sync_ipin_early", 32'(ipin_out), 32'(prev_ipin));
      tick();
      checkOutput("sync_sw", 32'(sw_out), 32'(vecs[v].exp_sw));
      checkOutput("sync_ipin", 32'(ipin_out), 32'(vecs[v].exp_ipin));
      prev_sw = vecs[v].exp_sw;
      prev_ipin = vecs[v].exp_ipin;
    end

    // Bounce rejection on button 0.
    for (int b = 0; b < 8; b++) begin
      applyStimulus(sw_in, bounce[b], ipin_in, 1'b0, '0);
      tick();
      checkOutput("bounce_out", 32'(btn_out[0]), 0);
      checkOutput("bounce_pulse", 32'(btn_pulse[0]), 0);
      checkOutput("bounce_pend", 32'(btn_pend[0]), 0);
    end
    for (int b = 0; b < 8; b++) begin
      tick();
      checkOutput("bounce_tail_out", 32'(btn_out[0]), 0);
      checkOutput("bounce_tail_pend", 32'(btn_pend[0]), 0);
    end

    // Clean press on button 2.
    applyStimulus(sw_in, 5'b00100, ipin_in, 1'b0, '0);
    tick();
    for (int e = 1; e <= 4; e++) begin
      tick();
      checkOutput("press_early_out", 32'(btn_out), 0);
    end
    tick();
    checkOutput("press_out", 32'(btn_out), 32'(5'b00100));
    checkOutput("press_pulse", 32'(btn_pulse), 32'(5'b00100));
    checkOutput("press_pend", 32'(btn_pend), 32'(5'b00100));
    tick();
    checkOutput("press_pulse_end", 32'(btn_pulse), 0);
    checkOutput("press_out_hold", 32'(btn_out), 32'(5'b00100));

    applyStimulus(sw_in, '0, ipin_in, 1'b0, '0);
    ticks(8);
    applyStimulus(sw_in, '0, ipin_in, 1'b1, 5'h1F);
    tick();
    checkOutput("clear_all", 32'(btn_pend), 0);

    // Clear collision: a new press on button 0 lands on a clearing edge.
    applyStimulus(sw_in, 5'b00011, ipin_in, 1'b0, '0);
    ticks(6);
    checkOutput("coll_pend_setup", 32'(btn_pend), 32'(5'b00011));
    applyStimulus(sw_in, 5'b00010, ipin_in, 1'b0, '0);
    ticks(7);
    checkOutput("coll_release0", 32'(btn_out), 32'(5'b00010));
    applyStimulus(sw_in, 5'b00011, ipin_in, 1'b0, '0);
    ticks(5);
    applyStimulus(sw_in, 5'b00011, ipin_in, 1'b1, 5'b00001);
    tick();
    checkOutput("coll_pulse", 32'(btn_pulse), 32'(5'b00001));
    checkOutput("coll_set_wins", 32'(btn_pend), 32'(5'b00011));
    applyStimulus(sw_in, 5'b00011, ipin_in, 1'b0, 5'h1F);
    tick();
    checkOutput("coll_mask_ignored", 32'(btn_pend), 32'(5'b00011));
    applyStimulus(sw_in, 5'b00011, ipin_in, 1'b1, 5'b00011);
    tick();
    checkOutput("coll_cleared", 32'(btn_pend), 0);
    applyStimulus(sw_in, '0, ipin_in, 1'b0, '0);
    ticks(8);

    // Hold and release button 4: one pulse, level falls DEB+1 edges after capture.
    pulses = 0;
    applyStimulus(sw_in, 5'b10000, ipin_in, 1'b0, '0);
    for (int e = 0; e < 20; e++) begin
      tick();
      if (btn_pulse[4]) pulses++;
    end
    applyStimulus(sw_in, '0, ipin_in, 1'b0, '0);
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (btn_pulse[4]) pulses++;
      checkOutput("release_out", 32'(btn_out[4]), (e < 6) ? 1 : 0);
    end
    for (int e = 0; e < 10; e++) begin
      tick();
      if (btn_pulse[4]) pulses++;
    end
    checkOutput("release_pulses", pulses, 1);
    checkOutput("release_pend", 32'(btn_pend[4]), 1);
    applyStimulus(sw_in, '0, ipin_in, 1'b1, 5'b10000);
    tick();
    checkOutput("release_pend_clr", 32'(btn_pend[4]), 0);
    applyStimulus(sw_in, '0, ipin_in, 1'b0, '0);

    // Mid-count asynchronous reset, then re-debounce of all buttons held high.
    applyStimulus(16'hFFFF, 5'h1F, 4'hF, 1'b0, '0);
    ticks(4);
    rst_n = 1'b0;
    model_reset();
    #1;
    checkOutput("rst_sw_out", 32'(sw_out), 0);
    checkOutput("rst_ipin_out", 32'(ipin_out), 0);
    checkOutput("rst_btn_out", 32'(btn_out), 0);
    checkOutput("rst_btn_pulse", 32'(btn_pulse), 0);
    checkOutput("rst_btn_pend", 32'(btn_pend), 0);
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      checkOutput("rst_redeb_early", 32'(btn_out), 0);
    end
    tick();
    checkOutput("rst_redeb_out", 32'(btn_out), 32'(5'h1F));
    checkOutput("rst_redeb_pulse", 32'(btn_pulse), 32'(5'h1F));
    checkOutput("rst_redeb_pend", 32'(btn_pend), 32'(5'h1F));
    tick();
    checkOutput("rst_pulse_end", 32'(btn_pulse), 0);
    checkOutput("rst_pend_hold", 32'(btn_pend), 32'(5'h1F));

    // Randomized traffic checked every cycle against the model.
    for (int c = 0; c < 600; c++) begin
      logic [N_BTN-1:0] b;
      b = btn_in;
      if ($urandom_range(0, 5) == 0) b[$urandom_range(0, N_BTN - 1)] ^= 1'b1;
      applyStimulus(N_SW'($urandom), b, N_IPIN'($urandom),
                    ($urandom_range(0, 4) == 0), N_BTN'($urandom));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
